iob_axi_master_bridge: RTL and testbench

IOB_AXI_MASTER_BRIDGE -- requirements
Module: iob_axi_master_bridge

---
 rtl/iob_axi_pkg.sv | 9 +
 rtl/iob_axi_master_bridge.sv | 129 ++++++++++++
 tb/tb_iob_axi_master_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_axi_pkg.sv
// iob_axi_pkg: AXI4 constants and bridge FSM encoding shared by the native-to-AXI bridge
package iob_axi_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_MOD  = 4'b0011;
    localparam logic [2:0] PROT_NS    = 3'b010;
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;
endpackage

// File: rtl/iob_axi_master_bridge.sv
// iob_axi_master_bridge: single-beat AXI4 master driven by a native valid/ready request port
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif
module iob_axi_master_bridge
    import iob_axi_pkg::*;
#(
    parameter int         ADDR_W = `DDR_ADDR_W,
    parameter int         DATA_W = 32,
    parameter logic [0:0] AXI_ID = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                error,
    output logic                m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    state_t              state, state_n;
    logic [ADDR_W-1:0]   a_q;
    logic [DATA_W-1:0]   d_q;
    logic [DATA_W/8-1:0] s_q;
    logic                aw_q, w_q, take, b_done, r_done, unused_ok;
    // ready gates capture so a requester holding valid is not re-accepted in its completion cycle
    assign take   = state == IDLE && valid && !ready;
    assign b_done = state == WR_RESP && m_axi_bvalid;
    assign r_done = state == RD_DATA && m_axi_rvalid;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = take ? (|wstrb ? WR : RD_ADDR) : IDLE;
            WR:      state_n = (!aw_q || m_axi_awready) && (!w_q || m_axi_wready) ? WR_RESP : WR;
            WR_RESP: state_n = m_axi_bvalid ? IDLE : WR_RESP;
            RD_ADDR: state_n = m_axi_arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_n = m_axi_rvalid ? IDLE : RD_DATA;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            aw_q  <= 1'b0;
            w_q   <= 1'b0;
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_n;
            ready <= b_done || r_done;
            error <= (b_done && m_axi_bresp != RESP_OKAY) || (r_done && m_axi_rresp != RESP_OKAY);
            if (take) begin
                a_q  <= addr;
                d_q  <= wdata;
                s_q  <= wstrb;
                aw_q <= |wstrb;
                w_q  <= |wstrb;
            end else begin
                if (m_axi_awready) aw_q <= 1'b0;
                if (m_axi_wready) w_q <= 1'b0;
            end
            if (r_done) rdata <= m_axi_rdata;
        end
    end
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = {a_q[ADDR_W-1:2], 2'b00};
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_MOD;
    assign m_axi_awprot  = PROT_NS;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awvalid = aw_q;
    assign m_axi_wdata   = d_q;
    assign m_axi_wstrb   = s_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = w_q;
    assign m_axi_bready  = state == WR_RESP;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = {a_q[ADDR_W-1:2], 2'b00};
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_MOD;
    assign m_axi_arprot  = PROT_NS;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = state == RD_ADDR;
    assign m_axi_rready  = state == RD_DATA;
    assign unused_ok     = m_axi_rlast ^ a_q[1] ^ a_q[0];
endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// tb_iob_axi_master_bridge: directed tests against a transaction-level model of the bridge
module tb_iob_axi_master_bridge;
    logic clk = 0, rst = 1, valid = 0;
    logic [31:0] addr = 0, wdata = 0, rdata;
    logic [3:0] wstrb = 0;
    logic ready, error;
    logic m_axi_awid, m_axi_awlock, m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
    logic m_axi_arid, m_axi_arlock, m_axi_arvalid, m_axi_rready;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
    logic [7:0] m_axi_awlen, m_axi_arlen;
    logic [2:0] m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
    logic [1:0] m_axi_awburst, m_axi_arburst;
    logic [3:0] m_axi_awcache, m_axi_awqos, m_axi_arcache, m_axi_arqos, m_axi_wstrb;
    logic m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0;
    logic m_axi_rvalid = 0, m_axi_rlast = 1;
    logic [1:0] m_axi_bresp = 0, m_axi_rresp = 0;
    logic [31:0] m_axi_rdata = 0;
    int checks = 0, failures = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0] cfg_bresp = 0, cfg_rresp = 0;
    logic [31:0] cfg_rdata = 0;
    logic [31:0] sa, sar, sw;
    logic snap_aw, snap_w, e;
    int lat, rcnt;
    localparam logic [25:0] CONST_FIELDS = {1'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b010, 4'd0};

    iob_axi_master_bridge dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .error(error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issue one request from posedge+1 and wait for its ready pulse, recording what the bus showed
    task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit drop, output int n);
        valid = 1; addr = a; wdata = d; wstrb = s; n = 0;
        do begin
            tick;
            n++;
            if (m_axi_awvalid) sa = m_axi_awaddr;
            if (m_axi_arvalid) sar = m_axi_araddr;
            if (m_axi_wvalid) sw = m_axi_wdata;
            if (n == 3) begin snap_aw = m_axi_awvalid; snap_w = m_axi_wvalid; end
        end while (!ready && n < 200);
        if (!ready) chk("ready_timeout", 0, 1);
        e = error;
        if (drop) valid = 0;
    endtask

    // AXI slave with programmable per-channel wait counts; acts on the falling edge
    initial begin : slave
        int awc, wc, bc, arc, rc;
        bit awd, wd, ard, hs_aw, hs_w, hs_b, hs_ar, hs_r;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        awd = 0; wd = 0; ard = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
                awd = 0; wd = 0; ard = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
            end else begin
                if (hs_aw) begin awd = 1; awc = 0; end
                if (hs_w) begin wd = 1; wc = 0; end
                if (hs_ar) begin ard = 1; arc = 0; end
                if (hs_b) begin m_axi_bvalid = 0; awd = 0; wd = 0; bc = 0; end
                if (hs_r) begin m_axi_rvalid = 0; ard = 0; rc = 0; end
                m_axi_awready = m_axi_awvalid && awc >= aw_wait;
                if (m_axi_awvalid && !m_axi_awready) awc++;
                m_axi_wready = m_axi_wvalid && wc >= w_wait;
                if (m_axi_wvalid && !m_axi_wready) wc++;
                m_axi_arready = m_axi_arvalid && arc >= ar_wait;
                if (m_axi_arvalid && !m_axi_arready) arc++;
                if (awd && wd && !m_axi_bvalid) begin
                    if (bc >= b_wait) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; end
                    else bc++;
                end
                if (ard && !m_axi_rvalid) begin
                    if (rc >= r_wait) begin
                        m_axi_rvalid = 1; m_axi_rresp = cfg_rresp; m_axi_rdata = cfg_rdata;
                    end else rc++;
                end
                hs_aw = m_axi_awvalid && m_axi_awready;
                hs_w  = m_axi_wvalid && m_axi_wready;
                hs_ar = m_axi_arvalid && m_axi_arready;
                hs_b  = m_axi_bvalid && m_axi_bready;
                hs_r  = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    // model: one outstanding request tracked as phases done; compared every cycle
    initial begin : compare
        bit busy, wr, awd, wd, ard, rd_y, er;
        bit ex_aw, ex_w, ex_b, ex_ar, ex_r;
        bit p_rst, p_valid, p_ready, p_aw, p_w, p_ar, p_b, p_r;
        logic [31:0] ta, td, mrd, p_addr, p_wdata, p_rdata;
        logic [3:0] ts, p_wstrb;
        logic [1:0] p_bresp, p_rresp;
        busy = 0; wr = 0; awd = 0; wd = 0; ard = 0; mrd = 0; ta = 0; td = 0; ts = 0;
        p_rst = 1; p_valid = 0; p_ready = 0; p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
        p_addr = 0; p_wdata = 0; p_rdata = 0; p_wstrb = 0; p_bresp = 0; p_rresp = 0;
        forever begin
            @(negedge clk);
            #1;
            rd_y = 0; er = 0;
            if (p_rst) begin
                busy = 0; awd = 0; wd = 0; ard = 0; mrd = 0;
            end else if (busy) begin
                if (p_aw) awd = 1;
                if (p_w) wd = 1;
                if (p_ar) ard = 1;
                if (p_b || p_r) begin
                    rd_y = 1;
                    er = p_b ? p_bresp != 0 : p_rresp != 0;
                    if (p_r) mrd = p_rdata;
                    busy = 0;
                end
            end else if (p_valid && !p_ready) begin
                busy = 1; wr = p_wstrb != 0; awd = 0; wd = 0; ard = 0;
                ta = p_addr & 32'hFFFF_FFFC; td = p_wdata; ts = p_wstrb;
            end
            ex_aw = busy && wr && !awd;
            ex_w  = busy && wr && !wd;
            ex_b  = busy && wr && awd && wd;
            ex_ar = busy && !wr && !ard;
            ex_r  = busy && !wr && ard;
            chk("awvalid", m_axi_awvalid, ex_aw);
            chk("wvalid", m_axi_wvalid, ex_w);
            chk("bready", m_axi_bready, ex_b);
            chk("arvalid", m_axi_arvalid, ex_ar);
            chk("rready", m_axi_rready, ex_r);
            chk("ready", ready, rd_y);
            chk("error", error, er);
            chk("rdata", rdata, mrd);
            chk("overlap", (m_axi_awvalid | m_axi_wvalid | m_axi_bready) &
                           (m_axi_arvalid | m_axi_rready), 0);
            chk("aw_const", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                             m_axi_awcache, m_axi_awprot, m_axi_awqos}, CONST_FIELDS);
            chk("ar_const", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                             m_axi_arcache, m_axi_arprot, m_axi_arqos}, CONST_FIELDS);
            chk("wlast", m_axi_wlast, 1);
            if (ex_aw) chk("awaddr", m_axi_awaddr, ta);
            if (ex_w) chk("wdata", m_axi_wdata, td);
            if (ex_w) chk("wstrb", m_axi_wstrb, ts);
            if (ex_ar) chk("araddr", m_axi_araddr, ta);
            p_rst = rst; p_valid = valid; p_ready = rd_y;
            p_addr = addr; p_wdata = wdata; p_wstrb = wstrb;
            p_aw = ex_aw && m_axi_awready;
            p_w  = ex_w && m_axi_wready;
            p_ar = ex_ar && m_axi_arready;
            p_b  = ex_b && m_axi_bvalid;
            p_r  = ex_r && m_axi_rvalid;
            p_bresp = m_axi_bresp; p_rresp = m_axi_rresp; p_rdata = m_axi_rdata;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        // zero-wait write
        run(32'h104, 32'hDEADBEEF, 4'hF, 1, lat);
        chk("t1_latency", lat, 3);
        chk("t1_awaddr", sa, 32'h104);
        chk("t1_wdata", sw, 32'hDEADBEEF);
        chk("t1_error", e, 0);
        tick;
        chk("t1_single_ready", ready, 0);
        // wready four cycles before awready
        aw_wait = 4;
        run(32'h200, 32'hA5A50001, 4'h3, 1, lat);
        chk("t2_latency", lat, 7);
        chk("t2_wvalid_dropped", snap_w, 0);
        chk("t2_awvalid_held", snap_aw, 1);
        chk("t2_error", e, 0);
        tick;
        chk("t2_single_ready", ready, 0);
        aw_wait = 0;
        // stalled read, then a write must leave rdata alone
        cfg_rdata = 32'h12345678; r_wait = 5;
        run(32'h107, 32'h0, 4'h0, 1, lat);
        chk("t3_latency", lat, 8);
        chk("t3_araddr", sar, 32'h104);
        chk("t3_rdata", rdata, 32'h12345678);
        chk("t3_error", e, 0);
        r_wait = 0;
        tick;
        run(32'h300, 32'h11112222, 4'hF, 1, lat);
        chk("t3_rdata_after_write", rdata, 32'h12345678);
        // slave errors on read and write
        tick;
        cfg_rresp = 2'b10; cfg_rdata = 32'hCAFEF00D;
        run(32'h40, 32'h0, 4'h0, 1, lat);
        chk("t4_latency", lat, 3);
        chk("t4_error", e, 1);
        tick;
        chk("t4_error_pulse", error, 0);
        chk("t4_idle_rready", m_axi_rready, 0);
        cfg_rresp = 0; cfg_bresp = 2'b11;
        run(32'h44, 32'h0000BEEF, 4'h1, 1, lat);
        chk("t4_bresp_error", e, 1);
        cfg_bresp = 0;
        tick;
        // reset while waiting for read data
        r_wait = 20; valid = 1; addr = 32'h500; wstrb = 0;
        repeat (4) tick;
        chk("t5_in_rd_data", m_axi_rready, 1);
        valid = 0; rst = 1;
        tick;
        rst = 0;
        chk("t5_rready", m_axi_rready, 0);
        chk("t5_arvalid", m_axi_arvalid, 0);
        chk("t5_ready", ready, 0);
        chk("t5_rdata", rdata, 0);
        rcnt = 0;
        repeat (25) begin tick; if (ready) rcnt++; end
        chk("t5_no_ready", rcnt, 0);
        r_wait = 0; cfg_rdata = 32'h0BADCAFE;
        run(32'h508, 32'h0, 4'h0, 1, lat);
        chk("t5_next_latency", lat, 3);
        chk("t5_next_rdata", rdata, 32'h0BADCAFE);
        tick;
        // back-to-back with valid held
        run(32'h600, 32'h01020304, 4'h1, 0, lat);
        chk("t6_first_latency", lat, 3);
        cfg_rdata = 32'h55AA55AA;
        run(32'h604, 32'h0, 4'h0, 1, lat);
        chk("t6_second_latency", lat, 4);
        chk("t6_rdata", rdata, 32'h55AA55AA);
        chk("t6_araddr", sar, 32'h604);
        repeat (3) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
